// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register and single-entry instruction buffer.
// Issues one level-held fetch request at a time and holds the result until the PC advances.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_stall,
    input  logic [2:0]  pc_src,
    input  logic [31:0] jump_target,
    input  logic [31:0] except_vector,
    input  logic [31:0] epc,
    input  logic [31:0] branch_target,
    input  logic [31:0] bp_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ack,
    input  logic [31:0] inst_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        if_addr_err,
    output logic        if_stall
);

    // state | meaning
    // FETCH | request outstanding or about to issue; if_stall high
    // FULL  | instruction (or AdEL marker) buffered; waits for pc_stall release

    typedef enum logic {
        FETCH = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt, next_pc;
    logic        rst_hold;
    logic        misaligned;
    logic        load_buf;
    logic [31:0] buf_inst, buf_pc;
    logic        buf_err;

    assign misaligned = (pc[1:0] != 2'b00);

    // rst_hold blocks the first cycle after reset so the first request lands one cycle later.
    assign inst_req  = (state == FETCH) && !misaligned && !rst_hold && !reset;
    assign inst_addr = pc;
    assign if_valid  = (state == FULL) && !reset;
    assign if_stall  = (state == FETCH) || reset;

    always_comb begin
        next_pc = pc + 32'd4;
        case (pc_src)
            3'd0:    next_pc = jump_target;
            3'd1:    next_pc = except_vector;
            3'd2:    next_pc = epc;
            3'd3:    next_pc = branch_target;
            3'd5:    next_pc = bp_target;
            default: next_pc = pc + 32'd4;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        load_buf  = 1'b0;
        buf_inst  = 32'd0;
        buf_pc    = pc;
        buf_err   = 1'b0;
        case (state)
            FETCH: begin
                if (!rst_hold) begin
                    if (misaligned) begin
                        load_buf  = 1'b1;
                        buf_err   = 1'b1;
                        state_nxt = FULL;
                    end else if (inst_ack) begin
                        load_buf  = 1'b1;
                        buf_inst  = inst_rdata;
                        state_nxt = FULL;
                    end
                end
            end
            FULL: begin
                if (!pc_stall) begin
                    pc_nxt    = next_pc;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            rst_hold    <= 1'b1;
            if_inst     <= 32'd0;
            if_pc       <= 32'd0;
            if_addr_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            rst_hold <= 1'b0;
            if (load_buf) begin
                if_inst     <= buf_inst;
                if_pc       <= buf_pc;
                if_addr_err <= buf_err;
            end
        end
    end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter: RESET_PC, 32'hBFC00000, PC loaded on reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  reset, synchronous, active-high.
REQ-004 Port: pc_stall  input  1  hold PC and the buffered instruction (control unit PC stall).
REQ-005 Port: pc_src  input  3  next-PC select: 0 jump, 1 except, 2 eret, 3 control hazard, 4 PC+4, 5 branch predict.
REQ-006 Port: jump_target  input  32  J/JAL target from ID.
REQ-007 Port: except_vector  input  32  exception/interrupt vector from the control unit.
REQ-008 Port: epc  input  32  return address for ERET.
REQ-009 Port: branch_target  input  32  corrected target for a mispredict or JR resolved in MEM.
REQ-010 Port: bp_target  input  32  predicted target.
REQ-011 Port: inst_req  output  1  instruction fetch request, level-held.
REQ-012 Port: inst_addr  output  32  fetch address; equals pc while inst_req=1.
REQ-013 Port: inst_ack  input  1  single-cycle completion pulse, valid only while inst_req=1.
REQ-014 Port: inst_rdata  input  32  instruction word, valid with inst_ack.
REQ-015 Port: if_pc  output  32  PC of the buffered instruction.
REQ-016 Port: if_inst  output  32  buffered instruction to the IF/ID register.
REQ-017 Port: if_valid  output  1  buffer holds a completed fetch.
REQ-018 Port: if_addr_err  output  1  buffered entry is a misaligned fetch (AdEL), if_inst=0.
REQ-019 Port: if_stall  output  1  fetch not complete; feeds the control unit stall input.

Function
REQ-020 Two states: FETCH (request outstanding or about to issue) and FULL (instruction buffered).
REQ-021 In FETCH with pc[1:0]==0: inst_req=1 and inst_addr=pc.
REQ-022 In FETCH: inst_addr held stable until inst_ack.
REQ-023 FETCH plus inst_ack: latch inst_rdata into if_inst and pc into if_pc; set if_addr_err=0; go to FULL next cycle.
REQ-024 Buffered-instruction latency: one cycle after inst_ack.
REQ-025 FETCH with pc[1:0]!=0: no request issued (inst_req=0); if_inst=0, if_addr_err=1, if_pc=pc; go to FULL next cycle.
REQ-026 if_stall=1 exactly when state==FETCH; it is registered-state based and not combinational on inst_ack.
REQ-027 if_valid=1 exactly when state==FULL.
REQ-028 In FETCH, pc_stall and pc_src are ignored; pc holds.
REQ-029 At most one request is outstanding.
REQ-030 FULL with pc_stall=1: pc, buffer and state hold; inst_req=0.
REQ-031 FULL with pc_stall=0: pc <= next_pc and state <= FETCH, so the request issues the following cycle.
REQ-032 next_pc selection:
  - pc_src 0: jump_target
  - 1: except_vector
  - 2: epc
  - 3: branch_target
  - 4: pc+4
  - 5: bp_target
  - 6, 7: pc+4
REQ-033 pc+4 is modulo 2^32: 32'hFFFFFFFC advances to 32'h00000000.
REQ-034 A redirect to a misaligned target loads that target and follows REQ-025; no request reaches memory.
REQ-035 inst_ack while not in FETCH, or while inst_req=0, is ignored.
REQ-036 if_inst/if_pc/if_addr_err change only on a FETCH-to-FULL transition or reset.

Reset
REQ-037 Reset has priority over every other input.
REQ-038 On reset: pc=RESET_PC, state=FETCH, if_inst=0, if_pc=0, if_addr_err=0.
REQ-039 Outputs during reset and in the first cycle after reset: inst_req=0, if_valid=0, if_stall=1.
REQ-040 First request after reset (to RESET_PC) issues in the second cycle after reset deasserts.
REQ-041 Reset during an outstanding fetch abandons it; the memory side shares the same reset, so no late inst_ack is returned.

Verification
REQ-042 Reset release, memory acks 2 cycles after req -> inst_addr=BFC00000; then if_valid=1, if_pc=BFC00000, if_inst=rdata; next request addr BFC00004 after pc_stall=0.
REQ-043 FULL, pc_stall=1 for 5 cycles -> inst_req=0, outputs unchanged; on release next fetch at PC+4.
REQ-044 FULL, pc_src=1, except_vector=BFC00380 -> next inst_addr=BFC00380; pc_src=2, epc=80001234 -> fetch at 80001234.
REQ-045 Redirect to 80000002 -> no inst_req; if_valid=1, if_addr_err=1, if_inst=0, if_pc=80000002 next cycle.
REQ-046 pc=FFFFFFFC, pc_src=4 -> next fetch at 00000000; spurious inst_ack in FULL -> buffer unchanged.
REQ-047 Reset asserted mid-fetch with pc=80000040 -> inst_req drops immediately; after release fetch restarts at BFC00000.
